// File: rtl/sdp_ram_bytewe_if.sv
// rtl/sdp_ram_bytewe_if.sv - write/read port bundle for the byte-enable simple dual-port RAM
interface sdp_ram_bytewe_if #(
    parameter int DATA_W = 16,
    parameter int COL_W  = 8,
    parameter int ADDR_W = 10
);
    localparam int NB_COL = DATA_W / COL_W;

    // Port A: write
    logic              ena;
    logic [NB_COL-1:0] wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dia;

    // Port B: read
    logic              enb;
    logic              regceb;
    logic [ADDR_W-1:0] addrb;
    logic [DATA_W-1:0] dob;
    logic              dob_vld;

    modport master (
        output ena, wea, addra, dia, enb, regceb, addrb,
        input  dob, dob_vld
    );

    modport slave (
        input  ena, wea, addra, dia, enb, regceb, addrb,
        output dob, dob_vld
    );
endinterface

// File: rtl/sdp_ram_bytewe.sv
// rtl/sdp_ram_bytewe.sv - simple dual-port RAM with per-column write enables and 1/2-cycle read latency
module sdp_ram_bytewe #(
    parameter int DATA_W  = 16,
    parameter int COL_W   = 8,
    parameter int ADDR_W  = 10,
    parameter int RD_LAT  = 1,
    parameter int WR_MODE = 0
) (
    input logic              clk,
    input logic              rst,
    sdp_ram_bytewe_if.slave  bus
);
    localparam int NB_COL = DATA_W / COL_W;
    localparam int DEPTH  = 2 ** ADDR_W;

    generate
        if (DATA_W % COL_W != 0) begin : g_bad_col
            $error("sdp_ram_bytewe: DATA_W must be a multiple of COL_W");
        end
        if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
            $error("sdp_ram_bytewe: RD_LAT must be 1 or 2");
        end
    endgenerate

    // Array has no reset so it maps onto block RAM; contents survive rst.
    logic [DATA_W-1:0] ram [DEPTH];

    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rd_s1;
    logic              vld_s1;
    logic [DATA_W-1:0] rd_s2;
    logic              vld_s2;

    // Read word for this edge: old content, with written columns bypassed in write-first mode.
    always_comb begin
        rd_word = ram[bus.addrb];
        if (WR_MODE == 1 && bus.ena && bus.addra == bus.addrb) begin
            for (int i = 0; i < NB_COL; i++) begin
                if (bus.wea[i]) begin
                    rd_word[i*COL_W +: COL_W] = bus.dia[i*COL_W +: COL_W];
                end
            end
        end
    end

    // Single write process; deliberately independent of rst so writes under reset still land.
    always_ff @(posedge clk) begin
        if (bus.ena) begin
            for (int i = 0; i < NB_COL; i++) begin
                if (bus.wea[i]) begin
                    ram[bus.addra][i*COL_W +: COL_W] <= bus.dia[i*COL_W +: COL_W];
                end
            end
        end
    end

    // Stage 1: capture the read word on enb; valid tracks enb every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_s1  <= '0;
            vld_s1 <= 1'b0;
        end else begin
            if (bus.enb) begin
                rd_s1 <= rd_word;
            end
            vld_s1 <= bus.enb;
        end
    end

    // Stage 2 output register: data holds without regceb, but the valid is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_s2  <= '0;
            vld_s2 <= 1'b0;
        end else if (bus.regceb) begin
            rd_s2  <= rd_s1;
            vld_s2 <= vld_s1;
        end else begin
            vld_s2 <= 1'b0;
        end
    end

    assign bus.dob     = (RD_LAT == 2) ? rd_s2  : rd_s1;
    assign bus.dob_vld = (RD_LAT == 2) ? vld_s2 : vld_s1;
endmodule

// File: doc/sdp_ram_bytewe.md
SDP_RAM_BYTEWE -- requirements
Module: sdp_ram_bytewe

Interface
REQ-001 SHALL have parameter DATA_W, default 16: data width in bits; must be a multiple of COL_W.
REQ-002 SHALL have parameter COL_W, default 8: byte-enable column width in bits.
REQ-003 SHALL have parameter ADDR_W, default 10: address width; depth = 2**ADDR_W words.
REQ-004 SHALL have parameter RD_LAT, default 1: read latency in cycles; legal values 1 or 2.
REQ-005 SHALL have parameter WR_MODE, default 0: collision behaviour; 0 = read-first, 1 = write-first.
REQ-006 SHALL derive NB_COL = DATA_W/COL_W; elaboration SHALL fail if DATA_W mod COL_W != 0 or RD_LAT is not in {1,2}.
REQ-007 clk  input  1  single clock; all state changes on its rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 ena  input  1  port A (write) enable.
REQ-010 wea  input  NB_COL  per-column write enable; bit i covers dia[i*COL_W +: COL_W].
REQ-011 addra  input  ADDR_W  write address.
REQ-012 dia  input  DATA_W  write data.
REQ-013 enb  input  1  port B (read) enable.
REQ-014 regceb  input  1  output-register clock enable; used only when RD_LAT=2.
REQ-015 addrb  input  ADDR_W  read address.
REQ-016 dob  output  DATA_W  registered read data.
REQ-017 dob_vld  output  1  high for one cycle when dob carries newly read data.

Function
REQ-018 Write: on a rising clk edge with ena=1, SHALL write column i of ram[addra] from dia for every wea[i]=1; columns with wea[i]=0 SHALL be unchanged.
REQ-019 Write: with ena=0 or wea all-zero, SHALL leave memory unchanged.
REQ-020 Read stage 1: on a rising clk edge with enb=1, SHALL capture ram[addrb] into the stage-1 register; with enb=0 the register SHALL hold its value.
REQ-021 RD_LAT=1: dob SHALL be the stage-1 register, so data appears one cycle after the enb/addrb sample.
REQ-022 RD_LAT=2: dob SHALL load from stage 1 on edges where regceb=1 and hold otherwise, so data appears two cycles after the enb sample when regceb=1.
REQ-023 dob_vld: a valid bit SHALL follow the data path; stage-1 valid = enb.
REQ-024 dob_vld, RD_LAT=2: stage-2 valid SHALL load stage-1 valid when regceb=1; when regceb=0 it SHALL clear to 0 while dob holds.
REQ-025 Collision: same edge with ena=1, any wea bit set, enb=1 and addra==addrb.
REQ-026 Collision, WR_MODE=0: the read SHALL return the pre-write word.
REQ-027 Collision, WR_MODE=1: the read SHALL return, per column, dia where wea[i]=1 and the old content where wea[i]=0.
REQ-028 Collision: the write SHALL complete per REQ-018 in both modes.
REQ-029 Addresses SHALL cover the full range 0..2**ADDR_W-1 with no wrap or aliasing.
REQ-030 Memory SHALL be inferable as block RAM: a single write process, with no reset or initialisation of array contents.

Reset
REQ-031 rst=1 SHALL asynchronously clear the stage-1 register, dob, and all valid bits to 0.
REQ-032 rst SHALL NOT alter memory contents.
REQ-033 A write presented on an edge while rst=1 SHALL still be performed.
REQ-034 A read in flight when rst asserts SHALL be discarded: dob_vld SHALL NOT pulse for it after rst deasserts.
REQ-035 After rst deasserts, the first enb=1 sample SHALL produce dob_vld after RD_LAT cycles.

Verification
REQ-036 Byte write: DATA_W=16.
- write 0xAAAA to address 5 with wea=11
- then write 0x1234 to address 5 with wea=01
- read address 5 -> dob=0xAA34, dob_vld=1 exactly 1 cycle later (RD_LAT=1)
REQ-037 Collision, WR_MODE=0: ram[7]=0x0F0F; same edge write 0xFFFF (wea=11) and read address 7 -> dob=0x0F0F; next read of address 7 -> 0xFFFF.
REQ-038 Collision, WR_MODE=1: ram[7]=0x0F0F; same edge write 0xAB00 with wea=10 and read address 7 -> dob=0xAB0F.
REQ-039 RD_LAT=2 back-to-back: reads of addresses 0,1,2 on consecutive cycles with regceb=1 -> data on cycles 2,3,4 with dob_vld high for 3 cycles.
- then one cycle of regceb=0 -> dob holds and dob_vld=0.
REQ-040 Reset mid-read: enb=1 at address 3, rst asserted asynchronously before the next edge -> dob=0 and dob_vld=0 immediately; no vld pulse after release; ram[3] still readable unchanged.
REQ-041 Boundary: write then read addresses 0 and 1023 (ADDR_W=10) -> correct data, no aliasing with address 0.
